alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 201 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Single-cycle ALU with iterative unsigned multiply/divide sharing one
// 2*WIDTH-bit work register; results land in y and, for MULTU/DIVU, in HI/LO.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             overflow,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] F_AND   = 4'b0000;
    localparam logic [3:0] F_OR    = 4'b0001;
    localparam logic [3:0] F_ADD   = 4'b0010;
    localparam logic [3:0] F_SUB   = 4'b0110;
    localparam logic [3:0] F_SLT   = 4'b0111;
    localparam logic [3:0] F_SLTU  = 4'b1111;
    localparam logic [3:0] F_MULTU = 4'b1000;
    localparam logic [3:0] F_DIVU  = 4'b1001;
    localparam logic [3:0] F_MFHI  = 4'b1010;
    localparam logic [3:0] F_MFLO  = 4'b1011;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               is_sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum;
    logic               ovf_c;
    logic               slt;
    logic               sltu;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_df;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] work_nxt;

    assign is_sub = (f == F_SUB) || (f == F_SLT) || (f == F_SLTU);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    assign ovf_c  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);

    // Differing signs decide the compare outright, so overflow never matters.
    assign slt  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
    assign sltu = (a[WIDTH-1] != b[WIDTH-1]) ? b[WIDTH-1] : sum[WIDTH-1];

    always_comb begin
        alu_y   = '0;
        alu_ovf = 1'b0;
        case (f)
            F_AND:  alu_y = a & b;
            F_OR:   alu_y = a | b;
            F_ADD,
            F_SUB: begin
                alu_y   = sum;
                alu_ovf = ovf_c;
            end
            F_SLT:  alu_y = {{(WIDTH-1){1'b0}}, slt};
            F_SLTU: alu_y = {{(WIDTH-1){1'b0}}, sltu};
            F_MFHI: alu_y = hi_q;
            F_MFLO: alu_y = lo_q;
            default: alu_y = '0;
        endcase
    end

    // Multiply: {acc, multiplier} shifts right, adding multiplicand on lsb.
    assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                     (work_q[0] ? {1'b0, opd_q} : '0);
    assign mul_nxt = {mul_sum, work_q[WIDTH-1:1]};

    // Divide: {rem, dividend/quotient} shifts left, trial subtract divisor.
    assign div_sh  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_df  = div_sh - {1'b0, opd_q};
    assign div_nxt = div_df[WIDTH]
                   ? {div_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                   : {div_df[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

    assign work_nxt = (state_q == S_MUL) ? mul_nxt : div_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opd_d   = opd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        y_d     = y_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (f == F_MULTU) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        work_d  = {{WIDTH{1'b0}}, b};
                        opd_d   = a;
                        busy_d  = 1'b1;
                    end else if (f == F_DIVU) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        work_d  = {{WIDTH{1'b0}}, a};
                        opd_d   = b;
                        busy_d  = 1'b1;
                    end else begin
                        y_d    = alu_y;
                        zero_d = (alu_y == '0);
                        ovf_d  = alu_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL,
            S_DIV: begin
                work_d = work_nxt;
                cnt_d  = cnt_q + CNTW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = work_nxt[2*WIDTH-1:WIDTH];
                    lo_d    = work_nxt[WIDTH-1:0];
                    y_d     = work_nxt[WIDTH-1:0];
                    zero_d  = (work_nxt[WIDTH-1:0] == '0);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            y_q     <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opd_q   <= opd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign y        = y_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected results are queued at issue
// and popped by a monitor on every done pulse.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   f = '0;
    logic [W-1:0] y;
    logic         zero;
    logic         overflow;
    logic         done;
    logic         busy;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .f        (f),
        .y        (y),
        .zero     (zero),
        .overflow (overflow),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] y;
        logic         z;
        logic         v;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           passed = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 want no pending op");
            end else begin
                e = sbq.pop_front();
                check("y", y, e.y);
                check("zero", W'(zero), W'(e.z));
                check("overflow", W'(overflow), W'(e.v));
            end
        end
    end

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic push(input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] z);
        exp_t            e;
        longint          s;
        longint unsigned p;
        e.y = '0;
        e.v = 1'b0;
        case (op)
            4'b0000: e.y = x & z;
            4'b0001: e.y = x | z;
            4'b0010: begin
                s = longint'($signed(x)) + longint'($signed(z));
                e.y = W'(s);
                e.v = (s > MAXS) || (s < MINS);
            end
            4'b0110: begin
                s = longint'($signed(x)) - longint'($signed(z));
                e.y = W'(s);
                e.v = (s > MAXS) || (s < MINS);
            end
            4'b0111: e.y = ($signed(x) < $signed(z)) ? W'(1) : W'(0);
            4'b1111: e.y = (x < z) ? W'(1) : W'(0);
            4'b1000: begin
                p = 64'(x) * 64'(z);
                m_hi = p[63:32];
                m_lo = p[31:0];
                e.y = m_lo;
            end
            4'b1001: begin
                if (z == '0) begin
                    m_lo = '1;
                    m_hi = x;
                end else begin
                    m_lo = x / z;
                    m_hi = x % z;
                end
                e.y = m_lo;
            end
            4'b1010: e.y = m_hi;
            4'b1011: e.y = m_lo;
            default: e.y = '0;
        endcase
        e.z = (e.y == '0);
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] z);
        a = x;
        b = z;
        f = op;
        start = 1'b1;
        push(op, x, z);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < W + 8) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            $display("FAIL timeout: got no done want done within %0d cycles", W + 8);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] z);
        @(negedge clk);
        issue(op, x, z);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7fff_ffff;
            2: return 32'h8000_0000;
            3: return 32'hffff_ffff;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops[11];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111,
                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0101};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_y", y, '0);
        check("rst_zero", W'(zero), W'(1));
        check("rst_ovf", W'(overflow), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_busy", W'(busy), W'(0));
        reset = 1'b0;

        run(4'b0010, 32'h7fff_ffff, 32'h0000_0001);
        check("add_done_next_edge", W'(done), W'(1));
        @(negedge clk);
        check("add_done_pulse_end", W'(done), W'(0));
        check("add_y_hold", y, 32'h8000_0000);
        check("add_ovf_hold", W'(overflow), W'(1));

        run(4'b0111, 32'h8000_0000, 32'h0000_0001);
        run(4'b1111, 32'h8000_0000, 32'h0000_0001);
        run(4'b0110, 32'h0000_0005, 32'h0000_0005);
        run(4'b0110, 32'h8000_0000, 32'h0000_0001);
        run(4'b0011, 32'h1234_5678, 32'h1);

        @(negedge clk);
        issue(4'b1000, 32'hffff_ffff, 32'hffff_ffff);
        @(negedge clk);
        start = 1'b0;
        check("mul_busy_first", W'(busy), W'(1));
        repeat (W - 1) @(negedge clk);
        check("mul_busy_last", W'(busy), W'(1));
        check("mul_no_early_done", W'(done), W'(0));
        @(negedge clk);
        check("mul_done_edge", W'(done), W'(1));
        check("mul_busy_clear", W'(busy), W'(0));
        run(4'b1010, '0, '0);
        run(4'b1011, '0, '0);

        run(4'b1001, 32'h0000_0100, 32'h0000_0007);
        run(4'b1010, '0, '0);
        run(4'b1001, 32'h0000_1234, 32'h0000_0000);
        run(4'b1010, '0, '0);

        // ADD request while the multiplier is busy must be dropped.
        @(negedge clk);
        issue(4'b1000, 32'h0001_2345, 32'h0000_6789);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'h1;
        b = 32'h2;
        f = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        run(4'b1011, '0, '0);

        @(negedge clk);
        issue(4'b1000, 32'h0000_0011, 32'h0000_0013);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(4'b0010, 32'h0000_0003, 32'h0000_0004);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done", W'(done), W'(1));

        @(negedge clk);
        issue(4'b1001, 32'hdead_beef, 32'h0000_0003);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_y", y, '0);
        check("arst_zero", W'(zero), W'(1));
        check("arst_ovf", W'(overflow), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_busy", W'(busy), W'(0));
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) @(negedge clk);
        run(4'b1010, '0, '0);
        run(4'b1011, '0, '0);
        run(4'b1000, 32'h3, 32'h5);
        run(4'b1011, '0, '0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = ops[$urandom_range(0, 10)];
            run(op, rnd_val(), rnd_val());
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL sb_drain: got %0d pending want 0", sbq.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
